dsp_mac_pipe: RTL and testbench

Parametrised multiply-accumulate pipeline. It is the generalised successor of the fixed single-DSP mult/multacc/multadd testcase, with all modes in one block and configurable register stages. It adds valid tracking, accumulator saturation with a sticky overflow flag, and round-then-shift output scaling. It sits as the DSP leaf under the co-sim golden/netlist benches.

---
 rtl/dsp_mac_pkg.sv | 39 +++
 rtl/dsp_mac_pipe_if.sv | 36 +++
 rtl/dsp_mac_acc_stage.sv | 61 ++++++
 rtl/dsp_mac_pipe.sv | 155 +++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared types and arithmetic helpers for the multiply-accumulate pipeline.
// The helpers work on a wide signed container so one definition serves every parameterisation.
package dsp_mac_pkg;

  typedef enum logic [2:0] {
    MULT = 3'd0,
    MACC = 3'd1,
    MADD = 3'd2
  } mode_e;

  localparam int MAX_W = 128;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [MAX_W-1:0] sat_clip(input logic signed [MAX_W-1:0] value,
                                                       input int width);
    logic signed [MAX_W-1:0] one, hi, lo;
    one = 1;
    hi  = (one <<< (width - 1)) - one;
    lo  = -hi - one;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Round half-up at the shift point, then arithmetic right shift.
  // Shifts at or beyond the field width collapse to the sign fill of the input.
  function automatic logic signed [MAX_W-1:0] round_shift(input logic signed [MAX_W-1:0] value,
                                                          input int shift,
                                                          input logic round,
                                                          input int width);
    logic signed [MAX_W-1:0] one, r;
    one = 1;
    if (shift >= width) return (value < 0) ? -one : '0;
    r = value;
    if (round && shift > 0) r = value + (one <<< (shift - 1));
    return r >>> shift;
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Operand, control and result bundle of the MAC pipeline.
// master drives operands and controls; slave is the pipeline itself.
interface dsp_mac_pipe_if #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 38
);
  logic                 valid_in;
  logic [A_WIDTH-1:0]   a;
  logic [B_WIDTH-1:0]   b;
  logic                 unsigned_a;
  logic                 unsigned_b;
  logic [2:0]           feedback;
  logic                 load_acc;
  logic                 subtract;
  logic [5:0]           acc_fir;
  logic [5:0]           shift_right;
  logic                 round;
  logic                 saturate_enable;
  logic [ACC_WIDTH-1:0] z;
  logic [B_WIDTH-1:0]   dly_b;
  logic                 valid_out;
  logic                 overflow;

  modport master (
    output valid_in, a, b, unsigned_a, unsigned_b, feedback, load_acc, subtract,
           acc_fir, shift_right, round, saturate_enable,
    input  z, dly_b, valid_out, overflow
  );

  modport slave (
    input  valid_in, a, b, unsigned_a, unsigned_b, feedback, load_acc, subtract,
           acc_fir, shift_right, round, saturate_enable,
    output z, dly_b, valid_out, overflow
  );
endinterface

// File: rtl/dsp_mac_acc_stage.sv
// Accumulator stage: operand extension, exact product, mode-dependent sum,
// saturation/wrap and the accumulator register with its sticky overflow flag.
module dsp_mac_acc_stage
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 38
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vld_p0,
  input  logic [A_WIDTH-1:0]          a_p0,
  input  logic [B_WIDTH-1:0]          b_p0,
  input  logic                        unsigned_a_p0,
  input  logic                        unsigned_b_p0,
  input  logic [2:0]                  feedback_p0,
  input  logic                        load_acc_p0,
  input  logic                        subtract_p0,
  input  logic [5:0]                  acc_fir_p0,
  input  logic                        saturate_enable_p0,
  output logic signed [ACC_WIDTH-1:0] acc_p1,
  output logic                        overflow_p1
);

  localparam int SW = ACC_WIDTH + 2;

  logic signed [SW-1:0]        ext_a, ext_b, prod, addend, sum;
  logic signed [MAX_W-1:0]     sum_w, clip_w;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        ovf;

  always_comb begin
    ext_a  = {{(SW-A_WIDTH){a_p0[A_WIDTH-1] & ~unsigned_a_p0}}, a_p0};
    ext_b  = {{(SW-B_WIDTH){b_p0[B_WIDTH-1] & ~unsigned_b_p0}}, b_p0};
    prod   = ext_a * ext_b;
    addend = subtract_p0 ? -prod : prod;
    sum    = prod;
    case (feedback_p0)
      MACC:    sum = load_acc_p0 ? prod : {{2{acc_p1[ACC_WIDTH-1]}}, acc_p1} + addend;
      MADD:    sum = (ext_a <<< acc_fir_p0) + addend;
      default: sum = prod;
    endcase
    sum_w    = sum;
    clip_w   = sat_clip(sum_w, ACC_WIDTH);
    ovf      = (clip_w != sum_w);
    acc_next = saturate_enable_p0 ? ACC_WIDTH'(clip_w) : ACC_WIDTH'(sum);
  end

  // ---- accumulator register (p0 -> p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1      <= '0;
      overflow_p1 <= 1'b0;
    end else if (vld_p0) begin
      acc_p1 <= acc_next;
      if (ovf) overflow_p1 <= 1'b1;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Multiply-accumulate pipeline: optional input register, accumulator stage,
// round-then-shift output scaling and optional output register.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 38,
  parameter int IN_REG    = 1,
  parameter int OUT_REG   = 1
) (
  input logic           clk,
  input logic           reset,
  dsp_mac_pipe_if.slave bus
);

  logic                 vld_p0;
  logic [A_WIDTH-1:0]   a_p0;
  logic [B_WIDTH-1:0]   b_p0;
  logic                 unsigned_a_p0, unsigned_b_p0;
  logic [2:0]           feedback_p0;
  logic                 load_acc_p0, subtract_p0;
  logic [5:0]           acc_fir_p0, shift_right_p0;
  logic                 round_p0, saturate_enable_p0;

  // ---- stage IN (input -> p0) ----
  generate
    if (IN_REG != 0) begin : g_in_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p0             <= 1'b0;
          a_p0               <= '0;
          b_p0               <= '0;
          unsigned_a_p0      <= 1'b0;
          unsigned_b_p0      <= 1'b0;
          feedback_p0        <= '0;
          load_acc_p0        <= 1'b0;
          subtract_p0        <= 1'b0;
          acc_fir_p0         <= '0;
          shift_right_p0     <= '0;
          round_p0           <= 1'b0;
          saturate_enable_p0 <= 1'b0;
        end else begin
          vld_p0             <= bus.valid_in;
          a_p0               <= bus.a;
          b_p0               <= bus.b;
          unsigned_a_p0      <= bus.unsigned_a;
          unsigned_b_p0      <= bus.unsigned_b;
          feedback_p0        <= bus.feedback;
          load_acc_p0        <= bus.load_acc;
          subtract_p0        <= bus.subtract;
          acc_fir_p0         <= bus.acc_fir;
          shift_right_p0     <= bus.shift_right;
          round_p0           <= bus.round;
          saturate_enable_p0 <= bus.saturate_enable;
        end
      end
    end else begin : g_in_comb
      always_comb begin
        vld_p0             = bus.valid_in;
        a_p0               = bus.a;
        b_p0               = bus.b;
        unsigned_a_p0      = bus.unsigned_a;
        unsigned_b_p0      = bus.unsigned_b;
        feedback_p0        = bus.feedback;
        load_acc_p0        = bus.load_acc;
        subtract_p0        = bus.subtract;
        acc_fir_p0         = bus.acc_fir;
        shift_right_p0     = bus.shift_right;
        round_p0           = bus.round;
        saturate_enable_p0 = bus.saturate_enable;
      end
    end
  endgenerate

  // ---- accumulator stage (p0 -> p1) ----
  logic signed [ACC_WIDTH-1:0] acc_p1;
  logic                        overflow_p1;
  logic                        vld_p1;
  logic [5:0]                  shift_right_p1;
  logic                        round_p1;

  dsp_mac_acc_stage #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc (
    .clk               (clk),
    .reset             (reset),
    .vld_p0            (vld_p0),
    .a_p0              (a_p0),
    .b_p0              (b_p0),
    .unsigned_a_p0     (unsigned_a_p0),
    .unsigned_b_p0     (unsigned_b_p0),
    .feedback_p0       (feedback_p0),
    .load_acc_p0       (load_acc_p0),
    .subtract_p0       (subtract_p0),
    .acc_fir_p0        (acc_fir_p0),
    .saturate_enable_p0(saturate_enable_p0),
    .acc_p1            (acc_p1),
    .overflow_p1       (overflow_p1)
  );

  // Scaling controls follow the sample into the accumulator so a held acc keeps its own scaling.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1         <= 1'b0;
      shift_right_p1 <= '0;
      round_p1       <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        shift_right_p1 <= shift_right_p0;
        round_p1       <= round_p0;
      end
    end
  end

  logic signed [MAX_W-1:0]     acc_w;
  logic signed [ACC_WIDTH-1:0] z_pre;

  always_comb begin
    acc_w = acc_p1;
    z_pre = ACC_WIDTH'(round_shift(acc_w, int'(shift_right_p1), round_p1, ACC_WIDTH));
  end

  // ---- stage OUT (p1 -> p2) ----
  logic signed [ACC_WIDTH-1:0] z_p2;
  logic                        vld_p2;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p2 <= 1'b0;
          z_p2   <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) z_p2 <= z_pre;
        end
      end
    end else begin : g_out_comb
      always_comb begin
        vld_p2 = vld_p1;
        z_p2   = z_pre;
      end
    end
  endgenerate

  assign bus.z         = z_p2;
  assign bus.valid_out = vld_p2;
  assign bus.dly_b     = b_p0;
  assign bus.overflow  = overflow_p1;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: directed samples push expected results,
// a negedge monitor pops and compares whenever valid_out is presented.
module tb_dsp_mac_pipe;
  localparam int AW  = 20;
  localparam int BW  = 18;
  localparam int ACW = 38;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACW)) bus ();

  dsp_mac_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACW), .IN_REG(1), .OUT_REG(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [ACW-1:0] z;
    logic           ovf;
    int             cyc;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest outstanding sample.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out: z=0x%0h with no sample outstanding", bus.z);
      end else begin
        e = sb.pop_front();
        check({e.name, "_z"},   64'(bus.z),      64'(e.z));
        check({e.name, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
        check({e.name, "_lat"}, 64'(cyc),        64'(e.cyc));
      end
    end
  end

  task automatic send(input string name, input bit push, input logic [2:0] fb,
                      input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic ld, input logic su, input logic [5:0] fir,
                      input logic [5:0] sh, input logic rnd, input logic sat,
                      input logic uns, input longint ez, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.valid_in        = 1'b1;
    bus.a               = a;
    bus.b               = b;
    bus.unsigned_a      = uns;
    bus.unsigned_b      = uns;
    bus.feedback        = fb;
    bus.load_acc        = ld;
    bus.subtract        = su;
    bus.acc_fir         = fir;
    bus.shift_right     = sh;
    bus.round           = rnd;
    bus.saturate_enable = sat;
    if (push) begin
      e.z    = ez[ACW-1:0];
      e.ovf  = eo;
      e.cyc  = cyc + LAT;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d samples outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic randomize_inputs();
    bus.valid_in        = 1'($urandom);
    bus.a               = AW'($urandom);
    bus.b               = BW'($urandom);
    bus.unsigned_a      = 1'($urandom);
    bus.unsigned_b      = 1'($urandom);
    bus.feedback        = 3'($urandom);
    bus.load_acc        = 1'($urandom);
    bus.subtract        = 1'($urandom);
    bus.acc_fir         = 6'($urandom);
    bus.shift_right     = 6'($urandom);
    bus.round           = 1'($urandom);
    bus.saturate_enable = 1'($urandom);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check({name, "_ovf_cleared"}, 64'(bus.overflow),  64'd0);
    check({name, "_vout_cleared"}, 64'(bus.valid_out), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    randomize_inputs();
    repeat (2) begin
      @(negedge clk);
      randomize_inputs();
    end
    @(negedge clk);
    check("reset_z",         64'(bus.z),         64'd0);
    check("reset_dly_b",     64'(bus.dly_b),     64'd0);
    check("reset_valid_out", 64'(bus.valid_out), 64'd0);
    check("reset_overflow",  64'(bus.overflow),  64'd0);
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.b        = 18'h00005;
    @(negedge clk);
    check("dly_b_one_cycle", 64'(bus.dly_b), 64'd5);
    idle(3);

    // MULT, signed: -3 * 5
    send("mult_neg", 1, 3'd0, 20'hFFFFD, 18'd5, 0, 0, 6'd0, 6'd0, 0, 0, 0, -15, 0);
    drain("mult");

    // MACC: load 2*3, then +1*4 three times with a bubble in the middle
    send("macc_load", 1, 3'd1, 20'd2, 18'd3, 1, 0, 6'd0, 6'd0, 0, 0, 0, 6, 0);
    send("macc_acc1", 1, 3'd1, 20'd1, 18'd4, 0, 0, 6'd0, 6'd0, 0, 0, 0, 10, 0);
    idle(1);
    send("macc_acc2", 1, 3'd1, 20'd1, 18'd4, 0, 0, 6'd0, 6'd0, 0, 0, 0, 14, 0);
    send("macc_acc3", 1, 3'd1, 20'd1, 18'd4, 0, 0, 6'd0, 6'd0, 0, 0, 0, 18, 0);
    drain("macc");

    // Round/shift in MULT mode
    send("rs_7_rnd",    1, 3'd0, 20'd7,      18'd1, 0, 0, 6'd0, 6'd1,  1, 0, 0, 4,  0);
    send("rs_7_trunc",  1, 3'd0, 20'd7,      18'd1, 0, 0, 6'd0, 6'd1,  0, 0, 0, 3,  0);
    send("rs_m7_rnd",   1, 3'd0, 20'hFFFF9,  18'd1, 0, 0, 6'd0, 6'd1,  1, 0, 0, -3, 0);
    send("rs_m7_sh63",  1, 3'd0, 20'hFFFF9,  18'd1, 0, 0, 6'd0, 6'd63, 1, 0, 0, -1, 0);
    send("rs_7_sh63",   1, 3'd0, 20'd7,      18'd1, 0, 0, 6'd0, 6'd63, 1, 0, 0, 0,  0);
    drain("round_shift");

    // Saturation: (2^20-1)*(2^18-1) unsigned overflows a 38-bit signed acc
    send("sat_load", 1, 3'd1, 20'hFFFFF, 18'h3FFFF, 1, 0, 6'd0, 6'd0, 0, 1, 1, 64'sd137438953471, 1);
    send("sat_acc",  1, 3'd1, 20'hFFFFF, 18'h3FFFF, 0, 0, 6'd0, 6'd0, 0, 1, 1, 64'sd137438953471, 1);
    drain("sat");
    pulse_reset("after_sat");

    // Same operands with wrap: low 38 bits of 274876596225 and of twice that
    send("wrap_load", 1, 3'd1, 20'hFFFFF, 18'h3FFFF, 1, 0, 6'd0, 6'd0, 0, 0, 1, -64'sd1310719, 1);
    send("wrap_acc",  1, 3'd1, 20'hFFFFF, 18'h3FFFF, 0, 0, 6'd0, 6'd0, 0, 0, 1, -64'sd2621438, 1);
    drain("wrap");
    pulse_reset("after_wrap");

    // MADD: (3<<4) + 3*2 and (3<<4) - 3*2
    send("madd_add", 1, 3'd2, 20'd3, 18'd2, 0, 0, 6'd4, 6'd0, 0, 0, 0, 54, 0);
    drain("madd_add");
    send("madd_sub", 1, 3'd2, 20'd3, 18'd2, 0, 1, 6'd4, 6'd0, 0, 0, 0, 42, 0);
    send("madd_killed", 0, 3'd2, 20'd3, 18'd2, 0, 0, 6'd4, 6'd0, 0, 0, 0, 54, 0);
    idle(1);
    @(negedge clk);
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("midop_reset_z",    64'(bus.z),         64'd0);
    check("midop_reset_vout", 64'(bus.valid_out), 64'd0);
    reset = 1'b0;
    idle(6);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
